// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the two-entry skid pipeline stage.
`default_nettype none

package pipe_stage_skid_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   function automatic logic [1:0] entry_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage latch and its neighbours.
`default_nettype none

interface pipe_stage_skid_if #(
   parameter int WIDTH = 128
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_halt;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_halt;
   logic [1:0]       count;
   logic             halted;

   modport master (
      output in_valid, in_data, in_halt, flush, out_ready,
      input  in_ready, out_valid, out_data, out_halt, count, halted
   );

   modport slave (
      input  in_valid, in_data, in_halt, flush, out_ready,
      output in_ready, out_valid, out_data, out_halt, count, halted
   );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// Two-entry (MAIN + SKID) pipeline latch with registered ready, flush and sticky halt.
`default_nettype none

module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int WIDTH          = 128,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   pipe_stage_skid_if.slave bus
);

   occ_t             state;
   occ_t             state_nxt;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] main_data_nxt;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] skid_data_nxt;
   logic             main_halt;
   logic             main_halt_nxt;
   logic             skid_halt;
   logic             skid_halt_nxt;
   logic             halted;
   logic             halted_nxt;
   logic             main_valid;
   logic             skid_valid;
   logic             ready;
   logic             push;
   logic             pop;

   // Valid bits are decoded from the occupancy state, so SKID-without-MAIN is unrepresentable.
   assign main_valid = (state != OCC_EMPTY);
   assign skid_valid = (state == OCC_FULL);
   assign ready      = !skid_valid && !halted;
   assign push       = bus.in_valid && ready;
   assign pop        = main_valid && bus.out_ready;

   always_comb begin
      state_nxt     = state;
      main_data_nxt = main_data;
      main_halt_nxt = main_halt;
      skid_data_nxt = skid_data;
      skid_halt_nxt = skid_halt;
      halted_nxt    = halted;

      if (bus.flush) begin
         state_nxt = OCC_EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_data_nxt = '0;
            main_halt_nxt = 1'b0;
            skid_data_nxt = '0;
            skid_halt_nxt = 1'b0;
         end
      end else begin
         if (push && bus.in_halt) begin
            halted_nxt = 1'b1;
         end
         case (state)
            OCC_EMPTY: begin
               if (push) begin
                  state_nxt     = OCC_ONE;
                  main_data_nxt = bus.in_data;
                  main_halt_nxt = bus.in_halt;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  main_data_nxt = bus.in_data;
                  main_halt_nxt = bus.in_halt;
               end else if (push) begin
                  state_nxt     = OCC_FULL;
                  skid_data_nxt = bus.in_data;
                  skid_halt_nxt = bus.in_halt;
               end else if (pop) begin
                  state_nxt = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (pop) begin
                  state_nxt     = OCC_ONE;
                  main_data_nxt = skid_data;
                  main_halt_nxt = skid_halt;
               end
            end
            default: begin
               state_nxt = OCC_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= OCC_EMPTY;
         main_data <= '0;
         main_halt <= 1'b0;
         skid_data <= '0;
         skid_halt <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nxt;
         main_data <= main_data_nxt;
         main_halt <= main_halt_nxt;
         skid_data <= skid_data_nxt;
         skid_halt <= skid_halt_nxt;
         halted    <= halted_nxt;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_data;
   assign bus.out_halt  = main_halt;
   assign bus.count     = entry_count(main_valid, skid_valid);
   assign bus.halted    = halted;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// Directed scoreboard bench for pipe_stage_skid.
`default_nettype none

module tb_pipe_stage_skid;
   localparam int WIDTH = 32;

   logic CLK;
   logic RST;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [WIDTH:0] exp_q[$];

   pipe_stage_skid_if #(.WIDTH(WIDTH)) bus ();

   pipe_stage_skid #(.WIDTH(WIDTH), .CLEAR_ON_FLUSH(1'b1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic h, input logic accept);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_halt  = h;
      if (v) chk("in_ready", 64'(bus.in_ready), 64'(accept));
      if (v && accept) exp_q.push_back({h, d});
   endtask

   // Scoreboard: a transfer happens at the coming edge when out_valid && out_ready and no flush.
   always @(negedge CLK) begin
      logic [WIDTH:0] e;
      if (!RST && !bus.flush && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(bus.out_data), 64'hDEAD);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(e[WIDTH-1:0]));
            chk("out_halt", 64'(bus.out_halt), 64'(e[WIDTH]));
         end
      end
   end

   initial begin
      RST           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h77;
      bus.in_halt   = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_halted", 64'(bus.halted), 64'd0);
      tick(); tick();
      chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
      RST          = 1'b0;
      bus.in_valid = 1'b0;

      // Latency-1 acceptance after reset
      drive(1'b1, 32'hA5, 1'b0, 1'b1);
      tick();
      chk("a5_valid", 64'(bus.out_valid), 64'd1);
      chk("a5_data", 64'(bus.out_data), 64'hA5);
      chk("a5_count", 64'(bus.count), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      chk("a5_empty", 64'(bus.count), 64'd0);

      // Full-throughput streaming
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b0, 1'b1);
         tick();
         chk("stream_count", 64'(bus.count), 64'd1);
         chk("stream_ready", 64'(bus.in_ready), 64'd1);
         chk("stream_data", 64'(bus.out_data), 64'(i));
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("stream_drained", 64'(bus.count), 64'd0);

      // Backpressure fills SKID; offered word while full must be refused
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h11, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'h22, 1'b0, 1'b1);
      tick();
      chk("bp_count", 64'(bus.count), 64'd2);
      chk("bp_data", 64'(bus.out_data), 64'h11);
      drive(1'b1, 32'h99, 1'b0, 1'b0);
      tick();
      chk("bp_stall_count", 64'(bus.count), 64'd2);
      chk("bp_stall_data", 64'(bus.out_data), 64'h11);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_pop1_count", 64'(bus.count), 64'd1);
      chk("bp_pop1_data", 64'(bus.out_data), 64'h22);
      tick();
      chk("bp_pop2_count", 64'(bus.count), 64'd0);

      // Flush beats push and pop
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h44, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'h55, 1'b0, 1'b1);
      tick();
      chk("fl_full", 64'(bus.count), 64'd2);
      exp_q.delete();
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h33, 1'b0, 1'b0);
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("fl_count", 64'(bus.count), 64'd0);
      chk("fl_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_data", 64'(bus.out_data), 64'd0);
      chk("fl_ready", 64'(bus.in_ready), 64'd1);
      tick(); tick();
      chk("fl_still_empty", 64'(bus.count), 64'd0);

      // Halt: sticky, blocks intake, entry still drains
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h66, 1'b1, 1'b1);
      tick();
      chk("halt_halted", 64'(bus.halted), 64'd1);
      chk("halt_in_ready", 64'(bus.in_ready), 64'd0);
      chk("halt_out_halt", 64'(bus.out_halt), 64'd1);
      chk("halt_out_data", 64'(bus.out_data), 64'h66);
      drive(1'b1, 32'h77, 1'b0, 1'b0);
      tick();
      chk("halt_count", 64'(bus.count), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      chk("halt_drained", 64'(bus.count), 64'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("halt_after_flush", 64'(bus.halted), 64'd1);
      RST = 1'b1;
      #1;
      chk("halt_rst_async", 64'(bus.halted), 64'd0);
      chk("halt_rst_ready", 64'(bus.in_ready), 64'd1);
      tick();
      RST = 1'b0;
      drive(1'b1, 32'hBB, 1'b0, 1'b1);
      tick();
      chk("post_rst_data", 64'(bus.out_data), 64'hBB);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick(); tick();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The module SHALL have parameter WIDTH, default 128, giving the payload bits per pipeline entry (packed word_t/flag bundle).
REQ-002 The module SHALL have parameter CLEAR_ON_FLUSH, default 1; when 1, flushed entries zero their data registers.
REQ-003 Port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: upstream stage offers an entry.
REQ-006 Port in_ready, output, 1 bit: this stage accepts an entry this cycle.
REQ-007 Port in_data, input, WIDTH bits: offered payload.
REQ-008 Port in_halt, input, 1 bit: offered entry carries the halt flag.
REQ-009 Port flush, input, 1 bit: discard all held entries (branch/jump squash).
REQ-010 Port out_valid, output, 1 bit: head entry is valid.
REQ-011 Port out_ready, input, 1 bit: downstream consumes the head entry (ihit/dhit-qualified).
REQ-012 Port out_data, output, WIDTH bits: head payload.
REQ-013 Port out_halt, output, 1 bit: head entry's halt flag.
REQ-014 Port count, output, 2 bits: number of valid entries held (0..2).
REQ-015 Port halted, output, 1 bit: sticky; a halt entry has been accepted.

Function
REQ-016 Storage SHALL be two entries: MAIN (head, drives out_*) and SKID (overflow); each holds data, halt and valid bits.
REQ-017 Occupancy states: EMPTY (none valid), ONE (MAIN only), FULL (MAIN and SKID); SKID valid without MAIN valid SHALL never occur.
REQ-018 in_ready SHALL be !SKID.valid && !halted, registered-state only, with no combinational path from out_ready.
REQ-019 push = in_valid && in_ready; pop = out_valid && out_ready; out_valid SHALL equal MAIN.valid.
REQ-020 EMPTY + push: entry to MAIN, next state ONE; output visible the following cycle (latency 1).
REQ-021 ONE + push + pop: new entry to MAIN, stays ONE (full throughput, one entry per cycle).
REQ-022 ONE + push, no pop: new entry to SKID, next state FULL.
REQ-023 ONE + pop, no push: next state EMPTY.
REQ-024 FULL + pop: SKID moves to MAIN, SKID invalid, next state ONE; push is impossible (in_ready=0).
REQ-025 No push and no pop: all entries SHALL hold unchanged (stall).
REQ-026 flush SHALL have priority over push and pop: next cycle count=0, out_valid=0, and the entry offered that cycle is dropped and not accepted.
REQ-027 With CLEAR_ON_FLUSH=1, a flush SHALL zero MAIN and SKID data and halt bits; with 0 they SHALL keep stale data and only clear valid.
REQ-028 A push with in_halt=1 SHALL set halted the next cycle; halted SHALL clear only on RST and SHALL NOT be cleared by flush.
REQ-029 Entries already held when halted rises SHALL still drain normally via out_ready.
REQ-030 count SHALL equal MAIN.valid + SKID.valid.
REQ-031 Payload width SHALL pass through unchanged; no arithmetic is applied to data.

Reset
REQ-032 On RST high, immediately and independent of CLK: MAIN and SKID valid=0, data=0, halt=0; halted=0.
REQ-033 During reset: out_valid=0, out_data=0, out_halt=0, count=0, in_ready=1.
REQ-034 RST asserted mid-transfer SHALL drop all held entries; first acceptance is possible on the first CLK edge after RST falls.

Structure
REQ-035 WIDTH-related bundle typedefs (packed stage payload struct for the EX/MEM and MEM/WB stages) SHALL live in cpu_types_pkg; the module itself uses only the WIDTH parameter.
REQ-036 The module SHALL be self-contained with no sub-modules; each stage latch in the datapath instantiates it once, with its own WIDTH.

Verification
REQ-037 Reset: assert RST with in_valid=1 -> out_valid=0, count=0, in_ready=1; after release, push 0xA5 -> out_data=0xA5 one cycle later.
REQ-038 Streaming: out_ready=1, push 0x1..0x8 on back-to-back cycles -> out_data 0x1..0x8 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-039 Backpressure: out_ready=0, push 0x11, 0x22 -> count=2, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22, no loss or duplication.
REQ-040 Flush priority: FULL, assert flush with in_valid=1 (0x33) and out_ready=1 -> next cycle count=0, out_valid=0, data=0, 0x33 never emitted.
REQ-041 Halt: push entry with in_halt=1 -> halted=1, in_ready=0 next cycle, entry still emitted with out_halt=1; flush leaves halted=1; RST clears it.
